// File: rtl/rs_synd_ctrl.sv
// Sequencing controller for the RS(204,188) syndrome datapath: frames input bytes,
// strobes the datapath, and hands final syndromes downstream. Stats: RS_SYND_CTRL_STATS_EN.
module rs_synd_ctrl #(
  parameter int N    = 204,
  parameter int NSYN = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        In_Byte,
  input  logic              In_Valid,
  input  logic              In_Sop,
  output logic              In_Ready,
  output logic [7:0]        Synd_Byte,
  output logic              Synd_En,
  output logic              Synd_Clr,
  input  logic [8*NSYN-1:0] Synd_Flat,
  output logic              Synd_Valid,
  input  logic              Synd_Ack,
  output logic              No_Err,
  output logic              Sync_Err,
  output logic [15:0]       Cw_Cnt,
  output logic [15:0]       Err_Cnt
);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, HOLD} state_t;

  localparam logic [7:0] LAST = 8'(N - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       flush_sub, flush_sub_nxt;
  logic       ready_nxt;
  logic [7:0] byte_nxt;
  logic       en_nxt, clr_nxt, valid_nxt, no_err_nxt, sync_err_nxt;
  logic       accept, synd_zero;

  assign accept    = In_Valid && In_Ready;
  assign synd_zero = (Synd_Flat == '0);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    flush_sub_nxt = flush_sub;
    byte_nxt      = Synd_Byte;
    en_nxt        = 1'b0;
    clr_nxt       = 1'b0;
    valid_nxt     = Synd_Valid;
    no_err_nxt    = No_Err;
    sync_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (In_Sop) begin
            en_nxt    = 1'b1;
            clr_nxt   = 1'b1;
            byte_nxt  = In_Byte;
            cnt_nxt   = 8'd1;
            state_nxt = ACC;
          end else begin
            sync_err_nxt = 1'b1;
          end
        end
      end
      ACC: begin
        if (accept) begin
          en_nxt   = 1'b1;
          byte_nxt = In_Byte;
          // A fresh Sop mid-codeword restarts framing; the partial word is dropped.
          if (In_Sop) begin
            clr_nxt      = 1'b1;
            sync_err_nxt = 1'b1;
            cnt_nxt      = 8'd1;
          end else begin
            cnt_nxt = cnt + 8'd1;
            if (cnt == LAST) begin
              state_nxt     = FLUSH;
              flush_sub_nxt = 1'b0;
            end
          end
        end
      end
      FLUSH: begin
        // Two idle cycles let the last byte propagate before the syndromes are judged.
        if (flush_sub) begin
          valid_nxt  = 1'b1;
          no_err_nxt = synd_zero;
          state_nxt  = HOLD;
        end else begin
          flush_sub_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (Synd_Ack) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE) || (state_nxt == ACC);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      flush_sub  <= 1'b0;
      In_Ready   <= 1'b0;
      Synd_Byte  <= 8'd0;
      Synd_En    <= 1'b0;
      Synd_Clr   <= 1'b0;
      Synd_Valid <= 1'b0;
      No_Err     <= 1'b0;
      Sync_Err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      flush_sub  <= flush_sub_nxt;
      In_Ready   <= ready_nxt;
      Synd_Byte  <= byte_nxt;
      Synd_En    <= en_nxt;
      Synd_Clr   <= clr_nxt;
      Synd_Valid <= valid_nxt;
      No_Err     <= no_err_nxt;
      Sync_Err   <= sync_err_nxt;
    end
  end

`ifdef RS_SYND_CTRL_STATS_EN
  logic [15:0] cw_cnt, err_cnt;
  logic        stat_inc;

  assign stat_inc = (state == FLUSH) && flush_sub;

  // Saturating counters, bumped on the same edge the syndromes are captured.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cw_cnt  <= 16'd0;
      err_cnt <= 16'd0;
    end else if (stat_inc) begin
      if (cw_cnt != 16'hFFFF) cw_cnt <= cw_cnt + 16'd1;
      if (!synd_zero && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign Cw_Cnt  = cw_cnt;
  assign Err_Cnt = err_cnt;
`else
  assign Cw_Cnt  = 16'd0;
  assign Err_Cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rs_synd_ctrl.sv
// Self-checking bench for rs_synd_ctrl with a toy syndrome datapath model and a
// scoreboard of expected No_Err values. Stats checks follow RS_SYND_CTRL_STATS_EN.
module tb_rs_synd_ctrl;
  localparam int N    = 204;
  localparam int NSYN = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        in_byte;
  logic              in_valid, in_sop, in_ready;
  logic [7:0]        synd_byte;
  logic              synd_en, synd_clr;
  logic [8*NSYN-1:0] synd_flat;
  logic              synd_valid, synd_ack, no_err, sync_err;
  logic [15:0]       cw_cnt, err_cnt;

  rs_synd_ctrl #(.N(N), .NSYN(NSYN)) dut (
    .Clk(clk), .Reset(rst_n), .In_Byte(in_byte), .In_Valid(in_valid), .In_Sop(in_sop),
    .In_Ready(in_ready), .Synd_Byte(synd_byte), .Synd_En(synd_en), .Synd_Clr(synd_clr),
    .Synd_Flat(synd_flat), .Synd_Valid(synd_valid), .Synd_Ack(synd_ack), .No_Err(no_err),
    .Sync_Err(sync_err), .Cw_Cnt(cw_cnt), .Err_Cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Toy datapath: each lane rotates and folds in the byte, so any lone nonzero byte survives.
  logic [7:0] syn [NSYN];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYN; i++) syn[i] <= 8'h00;
    end else if (synd_en) begin
      for (int i = 0; i < NSYN; i++)
        syn[i] <= synd_clr ? synd_byte : ({syn[i][6:0], syn[i][7]} ^ synd_byte);
    end
  end

  always_comb begin
    synd_flat = '0;
    for (int i = 0; i < NSYN; i++) synd_flat[8*i +: 8] = syn[i];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0, sync_cnt = 0, valid_cycles = 0, valid_rises = 0, clr_bad = 0;
  int valid_cyc = 0, last_acc = 0;
  logic prev_valid = 1'b0;
  logic sb_q [$];
  logic [15:0] cw_exp = 16'd0, err_exp = 16'd0;

  typedef struct {
    int         restart_at;
    int         bad_idx;
    logic [7:0] bad_val;
    bit         gappy;
    logic       exp_no_err;
    int         exp_sync;
    int         exp_en;
  } vec_t;

  vec_t vecs [6];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts strobes and compares No_Err against the scoreboard on each new Synd_Valid.
  always @(negedge clk) begin
    if (synd_en) en_cnt++;
    if (synd_clr && !synd_en) clr_bad++;
    if (sync_err) sync_cnt++;
    if (synd_valid) valid_cycles++;
    if (synd_valid && !prev_valid) begin
      valid_rises++;
      valid_cyc = cyc;
      if (sb_q.size() == 0) check_output("sb_unexpected_valid", 32'd1, 32'd0);
      else check_output("sb_no_err", {31'd0, no_err}, {31'd0, sb_q.pop_front()});
    end
    prev_valid = synd_valid;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] exp_cw();
`ifdef RS_SYND_CTRL_STATS_EN
    return cw_exp;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_err();
`ifdef RS_SYND_CTRL_STATS_EN
    return err_exp;
`else
    return 16'd0;
`endif
  endfunction

  task automatic apply_stimulus(input logic [7:0] b, input bit sop);
    in_valid = 1'b1;
    in_byte  = b;
    in_sop   = sop;
    for (int k = 0; k < 100 && !in_ready; k++) tick();
    if (!in_ready) check_output("ready_timeout", 32'd0, 32'd1);
    tick();
    last_acc = cyc;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic wait_valid(input int r0);
    for (int k = 0; k < 50 && valid_rises == r0; k++) tick();
    if (valid_rises == r0) check_output("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    int en0, s0, w0, r0;
    logic [7:0] b;
    en0 = en_cnt; s0 = sync_cnt; w0 = valid_cycles; r0 = valid_rises;
    for (int i = 0; i < v.restart_at; i++) begin
      apply_stimulus(8'hA5, i == 0);
      if (v.gappy) tick();
    end
    for (int i = 0; i < N; i++) begin
      b = (i == v.bad_idx) ? v.bad_val : 8'h00;
      if (i == N - 1) sb_q.push_back(v.exp_no_err);
      apply_stimulus(b, i == 0);
      if (v.gappy) tick();
    end
    wait_valid(r0);
    repeat (3) tick();
    cw_exp = sat_inc(cw_exp);
    if (!v.exp_no_err) err_exp = sat_inc(err_exp);
    check_output({tag, "_en_pulses"}, 32'(en_cnt - en0), 32'(v.exp_en));
    check_output({tag, "_sync_err"}, 32'(sync_cnt - s0), 32'(v.exp_sync));
    check_output({tag, "_valid_rises"}, 32'(valid_rises - r0), 32'd1);
    check_output({tag, "_valid_width"}, 32'(valid_cycles - w0), 32'd1);
    check_output({tag, "_valid_latency"}, 32'(valid_cyc - last_acc), 32'd2);
    check_output({tag, "_cw_cnt"}, {16'd0, cw_cnt}, {16'd0, exp_cw()});
    check_output({tag, "_err_cnt"}, {16'd0, err_cnt}, {16'd0, exp_err()});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, e0, bad;
    logic ne_snap;
    vec_t v;

    vecs[0] = '{restart_at: 0,   bad_idx: -1,  bad_val: 8'h00, gappy: 1'b0, exp_no_err: 1'b1, exp_sync: 0, exp_en: N};
    vecs[1] = '{restart_at: 0,   bad_idx: 37,  bad_val: 8'h5A, gappy: 1'b1, exp_no_err: 1'b0, exp_sync: 0, exp_en: N};
    vecs[2] = '{restart_at: 100, bad_idx: -1,  bad_val: 8'h00, gappy: 1'b0, exp_no_err: 1'b1, exp_sync: 1, exp_en: N + 100};
    vecs[3] = '{restart_at: 0,   bad_idx: 203, bad_val: 8'h01, gappy: 1'b1, exp_no_err: 1'b0, exp_sync: 0, exp_en: N};
    vecs[4] = '{restart_at: 0,   bad_idx: 0,   bad_val: 8'hFF, gappy: 1'b0, exp_no_err: 1'b0, exp_sync: 0, exp_en: N};
    vecs[5] = '{restart_at: 1,   bad_idx: -1,  bad_val: 8'h00, gappy: 1'b1, exp_no_err: 1'b1, exp_sync: 1, exp_en: N + 1};

    rst_n = 1'b0; synd_ack = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_byte = 8'h00;
    tick(); tick();
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("rst_synd_en", {31'd0, synd_en}, 32'd0);
    check_output("rst_synd_valid", {31'd0, synd_valid}, 32'd0);
    check_output("rst_no_err", {31'd0, no_err}, 32'd0);
    check_output("rst_sync_err", {31'd0, sync_err}, 32'd0);
    check_output("rst_synd_byte", {24'd0, synd_byte}, 32'd0);
    check_output("rst_cw_cnt", {16'd0, cw_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_output("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Stray non-Sop byte in IDLE.
    s0 = sync_cnt; e0 = en_cnt;
    in_valid = 1'b1; in_sop = 1'b0; in_byte = 8'h11;
    tick();
    in_valid = 1'b0;
    check_output("idle_stray_sync_err", {31'd0, sync_err}, 32'd1);
    check_output("idle_stray_no_en", {31'd0, synd_en}, 32'd0);
    tick();
    check_output("idle_stray_sync_err_drop", {31'd0, sync_err}, 32'd0);
    tick();
    check_output("idle_stray_sync_total", 32'(sync_cnt - s0), 32'd1);
    check_output("idle_stray_en_total", 32'(en_cnt - e0), 32'd0);

    for (int i = 0; i < 6; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: ack withheld while a new Sop byte waits at the input.
    synd_ack = 1'b0;
    v = vecs[0];
    s0 = valid_rises;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) sb_q.push_back(1'b1);
      apply_stimulus(8'h00, i == 0);
    end
    wait_valid(s0);
    cw_exp = sat_inc(cw_exp);
    ne_snap = no_err;
    in_valid = 1'b1; in_sop = 1'b1; in_byte = 8'h77;
    e0 = en_cnt; bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (in_ready || !synd_valid || no_err !== ne_snap || synd_en) bad++;
    end
    check_output("bp_stable", 32'(bad), 32'd0);
    check_output("bp_no_accept", 32'(en_cnt - e0), 32'd0);
    check_output("bp_cw_cnt", {16'd0, cw_cnt}, {16'd0, exp_cw()});
    synd_ack = 1'b1;
    tick();
    check_output("ack_valid_drop", {31'd0, synd_valid}, 32'd0);
    check_output("ack_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_sop = 1'b0;
    check_output("ack_next_en", {31'd0, synd_en}, 32'd1);
    check_output("ack_next_clr", {31'd0, synd_clr}, 32'd1);
    check_output("ack_next_byte", {24'd0, synd_byte}, 32'h77);

    // Reset in the middle of a codeword, at byte 150.
    for (int i = 2; i < 150; i++) apply_stimulus(8'h00, 1'b0);
    apply_stimulus(8'h3C, 1'b0);
    s0 = valid_rises;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_en", {31'd0, synd_en}, 32'd0);
    check_output("async_rst_byte", {24'd0, synd_byte}, 32'd0);
    check_output("async_rst_ready", {31'd0, in_ready}, 32'd0);
    check_output("async_rst_cw_cnt", {16'd0, cw_cnt}, 32'd0);
    cw_exp = 16'd0; err_exp = 16'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_output("rst2_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst2_no_valid", 32'(valid_rises - s0), 32'd0);
    check_output("rst2_sb_empty", 32'(sb_q.size()), 32'd0);
    run_vector(vecs[0], "post_rst");

`ifdef RS_SYND_CTRL_STATS_EN
    force dut.cw_cnt = 16'hFFFE;
    force dut.err_cnt = 16'hFFFE;
    tick();
    release dut.cw_cnt;
    release dut.err_cnt;
    cw_exp = 16'hFFFE; err_exp = 16'hFFFE;
    run_vector(vecs[4], "sat1");
    run_vector(vecs[4], "sat2");
    check_output("sat_cw_hold", {16'd0, cw_cnt}, 32'h0000FFFF);
`endif

    check_output("clr_without_en", 32'(clr_bad), 32'd0);
    check_output("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
